// File: rtl/ama_riscv_main_mem_if.sv
// rv_if: ready/valid channel carrying one W-bit payload per handshake
interface rv_if #(parameter int W = 32) ();
  logic [W-1:0] data;
  logic valid;
  logic ready;
  modport TX (output data, output valid, input ready);
  modport RX (input data, input valid, output ready);
endinterface

// File: rtl/ama_riscv_main_mem.sv
// ama_riscv_main_mem: fixed-latency in-order block read responder with credit-based backpressure
module ama_riscv_main_mem #(
  parameter int DEPTH = 4096,
  parameter int LATENCY = 1,
  parameter int FIFO_DEPTH = 4,
  parameter string MEM_INIT = "",
  parameter int MEM_ADDR_BUS = 32,
  parameter int MEM_DATA_BUS = 128
) (
  input logic clk,
  input logic rst_n,
  rv_if.RX req_mem,
  rv_if.TX rsp_mem
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = IW + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0 || AW > MEM_ADDR_BUS) begin : g_bad_depth
    $error("DEPTH must be a power of 2 addressable by MEM_ADDR_BUS");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("LATENCY must be in 1..4");
  end
  if (FIFO_DEPTH < LATENCY || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of 2 and >= LATENCY");
  end
  logic [MEM_DATA_BUS-1:0] mem [DEPTH];
  logic [MEM_DATA_BUS-1:0] fifo [2**IW];
  logic [MEM_DATA_BUS-1:0] rd, wd, last;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] outstanding;
  logic acc, pop, wv, up, unused_addr;
  assign rd = mem[req_mem.data[AW-1:0]];
  assign unused_addr = ^(req_mem.data >> AW);
  assign req_mem.ready = up && (outstanding < CW'(FIFO_DEPTH));
  assign rsp_mem.valid = wp != rp;
  assign rsp_mem.data = rsp_mem.valid ? fifo[rp[IW-1:0]] : last;
  assign acc = req_mem.valid && req_mem.ready;
  assign pop = rsp_mem.valid && rsp_mem.ready;
  if (LATENCY == 1) begin : g_direct
    assign wv = acc;
    assign wd = rd;
  end else begin : g_pipe
    logic [LATENCY-2:0] pv;
    logic [MEM_DATA_BUS-1:0] pd [LATENCY-1];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pv <= '0;
      else pv <= (pv << 1) | (LATENCY-1)'(acc);
    always_ff @(posedge clk) begin
      pd[0] <= rd;
      for (int i = LATENCY - 2; i > 0; i--) pd[i] <= pd[i-1];
    end
    assign wv = pv[LATENCY-2];
    assign wd = pd[LATENCY-2];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      up <= 1'b0;
      wp <= '0;
      rp <= '0;
      outstanding <= '0;
      last <= '0;
    end else begin
      up <= 1'b1;
      if (wv) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      if (pop) last <= rsp_mem.data;
      outstanding <= outstanding + CW'(acc) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (wv) fifo[wp[IW-1:0]] <= wd;
endmodule
